// File: rtl/round_judge.sv
// round_judge: sequences Tron rounds, judges each outcome from the crash flags and ends the match at WIN_LIMIT wins.
module round_judge #(
  parameter int TIE_WINDOW = 4,
  parameter int HOLDOFF    = 25000000,
  parameter int WIN_LIMIT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       crash_p1,
  input  logic       crash_p2,
  output logic       p1_win,
  output logic       p2_win,
  output logic       draw,
  output logic       round_done,
  output logic       round_active,
  output logic       freeze,
  output logic       match_over,
  output logic [1:0] winner
);
  localparam int TW = $clog2(TIE_WINDOW + 2);
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam int CW = $clog2(WIN_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, RUN, TIE_WAIT, REPORT, HOLD, MATCH_END} state_t;
  state_t state, state_n;
  logic [1:0] outcome, res_n;
  logic [TW-1:0] tie_cnt;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] tally1, tally2;
  logic start_d, first;
  wire start_rise = start & ~start_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_d    <= 1'b0;
      first      <= 1'b0;
      tie_cnt    <= '0;
      hold_cnt   <= '0;
      tally1     <= '0;
      tally2     <= '0;
      outcome    <= 2'b00;
      match_over <= 1'b0;
      winner     <= 2'b00;
    end else begin
      state   <= state_n;
      start_d <= start;
      if (state == RUN) begin
        first   <= crash_p2;
        tie_cnt <= TW'(TIE_WINDOW);
      end else if (state == TIE_WAIT)
        tie_cnt <= tie_cnt - TW'(1);
      if (state == REPORT)
        hold_cnt <= HW'(HOLDOFF);
      else if (state == HOLD)
        hold_cnt <= hold_cnt - HW'(1);
      // Tallies and the match result latch on entry to REPORT so match_over/winner show in that cycle.
      if (state_n == REPORT) begin
        outcome <= res_n;
        if (res_n == 2'b01) begin
          tally1 <= tally1 + CW'(1);
          if (tally1 == CW'(WIN_LIMIT - 1)) begin
            match_over <= 1'b1;
            winner     <= 2'b01;
          end
        end
        if (res_n == 2'b10) begin
          tally2 <= tally2 + CW'(1);
          if (tally2 == CW'(WIN_LIMIT - 1)) begin
            match_over <= 1'b1;
            winner     <= 2'b10;
          end
        end
      end
    end
  end
  always_comb begin
    state_n = state;
    res_n   = 2'b00;
    case (state)
      IDLE: if (start_rise) state_n = RUN;
      RUN:
        if (crash_p1 & crash_p2) begin
          state_n = REPORT;
          res_n   = 2'b11;
        end else if (crash_p1 | crash_p2) begin
          if (TIE_WINDOW == 0) begin
            state_n = REPORT;
            res_n   = crash_p1 ? 2'b10 : 2'b01;
          end else
            state_n = TIE_WAIT;
        end
      TIE_WAIT:
        if (first ? crash_p1 : crash_p2) begin
          state_n = REPORT;
          res_n   = 2'b11;
        end else if (tie_cnt == TW'(1)) begin
          state_n = REPORT;
          res_n   = first ? 2'b01 : 2'b10;
        end
      REPORT: state_n = match_over ? MATCH_END : (HOLDOFF == 0 ? IDLE : HOLD);
      HOLD: if (hold_cnt == HW'(1)) state_n = IDLE;
      default: state_n = state;
    endcase
  end
  always_comb begin
    p1_win       = state == REPORT && outcome == 2'b01;
    p2_win       = state == REPORT && outcome == 2'b10;
    draw         = state == REPORT && outcome == 2'b11;
    round_done   = state == REPORT;
    round_active = state == RUN || state == TIE_WAIT;
    freeze       = ~round_active;
  end
endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: directed checks of round_judge with TIE_WINDOW=4, HOLDOFF=8, WIN_LIMIT=3.
module tb_round_judge;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, crash_p1 = 1'b0, crash_p2 = 1'b0;
  logic p1_win, p2_win, draw, round_done, round_active, freeze, match_over;
  logic [1:0] winner;
  int checks = 0, errors = 0;
  round_judge #(.TIE_WINDOW(4), .HOLDOFF(8), .WIN_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .crash_p1(crash_p1), .crash_p2(crash_p2),
    .p1_win(p1_win), .p2_win(p2_win), .draw(draw), .round_done(round_done),
    .round_active(round_active), .freeze(freeze), .match_over(match_over), .winner(winner)
  );
  always #5 clk = ~clk;
  wire [3:0] pulses = {p1_win, p2_win, draw, round_done};
  wire [3:0] status = {round_active, freeze, match_over, 1'b0} | {2'b00, winner};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic new_round(input string tag);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk(tag, {3'b000, round_active}, 4'b0001);
  endtask
  task automatic quiet(input string tag, input int n, input logic act);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {pulses[3:1], round_active}, {3'b000, act});
    end
  endtask
  initial begin
    tick();
    tick();
    chk("reset_pulses", pulses, 4'b0000);
    chk("reset_status", {round_active, freeze, winner}, 4'b0100);
    chk("reset_match", {3'b000, match_over}, 4'b0000);
    reset = 1'b0;
    // Async reset in the middle of a tie window
    start = 1'b1;
    tick();
    chk("t1_run", {3'b000, round_active}, 4'b0001);
    crash_p1 = 1'b1;
    tick();
    tick();
    chk("t1_tiewait", {pulses[3:1], round_active}, 4'b0001);
    reset = 1'b1;
    #1;
    chk("t1_async_pulses", pulses, 4'b0000);
    chk("t1_async_status", status, 4'b0100);
    tick();
    reset = 1'b0;
    crash_p1 = 1'b0;
    start = 1'b0;
    quiet("t1_no_pulse", 8, 1'b0);
    // Clean round: p1 crashes alone, p2 wins after the tie window
    start = 1'b1;
    tick();
    chk("t2_run", {3'b000, round_active}, 4'b0001);
    crash_p1 = 1'b1;
    quiet("t2_tiewait", 4, 1'b1);
    tick();
    chk("t2_p2win", pulses, 4'b0101);
    chk("t2_status", status, 4'b0100);
    crash_p1 = 1'b0;
    tick();
    chk("t2_pulse_end", pulses, 4'b0000);
    quiet("t2_held_start", 14, 1'b0);
    new_round("t3_run1");
    // Same-cycle crash is an immediate draw
    crash_p1 = 1'b1;
    crash_p2 = 1'b1;
    tick();
    chk("t3_draw_same", pulses, 4'b0011);
    crash_p1 = 1'b0;
    crash_p2 = 1'b0;
    tick();
    chk("t3_draw_end", pulses, 4'b0000);
    repeat (9) tick();
    new_round("t3_run2");
    // Other player crashes in the last tie-window cycle
    crash_p2 = 1'b1;
    quiet("t3_tiewait2", 4, 1'b1);
    crash_p1 = 1'b1;
    tick();
    chk("t3_draw_late", pulses, 4'b0011);
    crash_p1 = 1'b0;
    crash_p2 = 1'b0;
    repeat (10) tick();
    new_round("t3_run3");
    crash_p1 = 1'b1;
    quiet("t3_tiewait3", 4, 1'b1);
    tick();
    chk("t3_p2win", pulses, 4'b0101);
    chk("t3_no_match", {3'b000, match_over}, 4'b0000);
    crash_p1 = 1'b0;
    start = 1'b0;
    // Start pulse inside holdoff is discarded
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    quiet("t4_holdoff", 9, 1'b0);
    start = 1'b1;
    tick();
    chk("t4_run", {3'b000, round_active}, 4'b0001);
    // p1 takes three rounds and ends the match
    for (int r = 0; r < 3; r++) begin
      if (r > 0) new_round("t5_run");
      crash_p2 = 1'b1;
      quiet("t5_tiewait", 4, 1'b1);
      tick();
      chk("t5_p1win", pulses, 4'b1001);
      chk("t5_match", {1'b0, match_over, winner}, r == 2 ? 4'b0101 : 4'b0000);
      crash_p2 = 1'b0;
      repeat (10) tick();
    end
    chk("t5_match_end", status, 4'b0111);
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      crash_p1 = i[1];
      crash_p2 = ~i[0];
      tick();
      chk("t5_frozen", pulses, 4'b0000);
      chk("t5_hold_status", status, 4'b0111);
    end
    reset = 1'b1;
    #1;
    chk("t5_reset", status, 4'b0100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/round_judge.md
Name: round_judge

Overview:
- Decides the outcome of each Tron round from the two players' crash flags.
- Emits one-cycle p1_win / p2_win / draw pulses plus a round_done strobe.
- Sits directly upstream of the score counter / hex display stage, which consumes those pulses.
- Sequences rounds (idle, run, tie window, report, holdoff) and ends the match when either player reaches WIN_LIMIT round wins.

Parameters:
- TIE_WINDOW, 4: cycles after the first crash during which the other player's crash turns the round into a draw; 0 means draw only on a same-cycle crash.
- HOLDOFF, 25000000: cycles spent frozen after a reported round before a new start is accepted; 0 skips the holdoff.
- WIN_LIMIT, 10: round wins that end the match; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  round start request; level input, internally rising-edge detected.
- crash_p1  in  1  player 1 has crashed (level from game logic).
- crash_p2  in  1  player 2 has crashed (level from game logic).
- p1_win  out  1  one-cycle pulse: player 1 won the round.
- p2_win  out  1  one-cycle pulse: player 2 won the round.
- draw  out  1  one-cycle pulse: round drawn.
- round_done  out  1  one-cycle pulse; equals p1_win | p2_win | draw (the "someone won" enable downstream).
- round_active  out  1  high while in RUN or TIE_WAIT.
- freeze  out  1  equals ~round_active; game logic halts motion when high.
- match_over  out  1  level; high in MATCH_END.
- winner  out  2  match winner: 01 = p1, 10 = p2, 00 = none.

Behaviour:
- Reset (async, any state, including mid-round or mid-holdoff):
  - State goes to IDLE; tallies, tie counter, holdoff counter and start_d clear to 0.
  - Outputs: p1_win = p2_win = draw = round_done = 0, round_active = 0, freeze = 1, match_over = 0, winner = 00.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Start edge: start_rise = start & ~start_d; start_d is registered every cycle. A start held high across holdoff or MATCH_END never launches a round by itself.
- IDLE: start_rise moves to RUN. Crash inputs are ignored.
- RUN (crash inputs are sampled from the first RUN cycle; a crash already asserted counts):
  - crash_p1 & crash_p2 in the same cycle: REPORT with outcome draw.
  - Exactly one crash, TIE_WINDOW = 0: REPORT with the other player as winner.
  - Exactly one crash, TIE_WINDOW > 0: record first_crasher, load tie_cnt = TIE_WINDOW, go to TIE_WAIT.
- TIE_WAIT, evaluated each cycle:
  - Other player's crash high: REPORT, draw.
  - Else, tie_cnt == 1: REPORT, survivor wins.
  - Else: decrement tie_cnt.
  - The first crasher's input is don't-care.
- Timing: first crash sampled at cycle N gives TIE_WAIT in cycles N+1..N+TIE_WINDOW and the REPORT pulse in cycle N+TIE_WINDOW+1. A same-cycle crash at N gives REPORT in cycle N+1.
- REPORT (exactly one cycle):
  - Asserts exactly one of p1_win / p2_win / draw, together with round_done.
  - The winner's tally increments by 1; a draw changes no tally.
  - Tally width is clog2(WIN_LIMIT+1); a tally never exceeds WIN_LIMIT.
  - If the incremented tally equals WIN_LIMIT, go to MATCH_END; else HOLDOFF, or IDLE if HOLDOFF = 0.
- HOLDOFF:
  - Counts HOLDOFF cycles with start and crash inputs ignored, then goes to IDLE.
  - A start rise during holdoff is discarded, not queued.
- MATCH_END:
  - Terminal state: match_over = 1; winner set to 01 or 10 from the REPORT cycle onward.
  - start and crash inputs are ignored; only reset leaves this state.
- freeze is high in IDLE, REPORT, HOLDOFF and MATCH_END.

Test Plan (TIE_WINDOW=4, HOLDOFF=8, WIN_LIMIT=3):
1. Reset mid-TIE_WAIT (crash_p1 at cycle 10, reset at cycle 12) -> all outputs at reset values next cycle, no pulse ever emitted, and the next start_rise runs a clean round.
2. Start rise, then crash_p1 alone at cycle 10 (crash_p2 stays 0) -> p2_win = round_done = 1 in cycle 15 only; round_active low from cycle 15; a start held high through holdoff launches nothing until it is toggled.
3. Start, then crash_p1 and crash_p2 both rising at cycle 20 -> draw = 1 in cycle 21 only; tallies unchanged. Second round: crash_p2 at 30, crash_p1 at 34 -> draw in cycle 35. Third round: crash_p1 at 40 -> p2_win in cycle 45.
4. Start pulse during HOLDOFF cycles 2..7 -> ignored, state returns to IDLE after 8 cycles; a fresh start_rise then enters RUN.
5. Three rounds won by p1 (crash_p2 only) -> third REPORT asserts p1_win, match_over = 1, winner = 01 from that cycle; further starts and crashes produce no pulses until reset.
